// File: rtl/module_pixel_stream_feed_pkg.sv
// Shared definitions for the pixel stream feeder and outcome collector.
// FSM encoding and width helper.
package module_pixel_stream_feed_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Address/counter width for v entries, never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/module_pixel_stream_feed_pixel_pos_counter.sv
// Row-major row/col position counter for the pixel feeder.
// Decodes start-of-row, end-of-frame and full-window flags.
module pixel_pos_counter #(
  parameter int length = 8,
  parameter int column = 3,
  parameter int CW     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_sol,
  output logic          o_eof,
  output logic          o_win
);

  localparam logic [CW-1:0] LAST   = CW'(length - 1);
  localparam logic [CW-1:0] WSTART = CW'(column - 1);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;

  // Column wraps at the row end and carries into the row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (r_col == LAST) begin
        r_col <= '0;
        r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row = r_row;
  assign o_col = r_col;
  assign o_sol = (r_col == '0);
  assign o_eof = (r_row == LAST) && (r_col == LAST);
  assign o_win = (r_row >= WSTART) && (r_col >= WSTART);

endmodule

// File: rtl/module_pixel_stream_feed.sv
// Feature-map buffer that streams one map row-major into the conv engine.
// Each pixel carries row/col, start-of-row, end-of-frame and window tags.
module module_pixel_stream_feed
  import module_pixel_stream_feed_pkg::*;
#(
  parameter  int WIDTH  = 18,
  parameter  int length = 8,
  parameter  int column = 3,
  localparam int AW     = clog2(length * length),
  localparam int CW     = clog2(length)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_row,
  output logic [CW-1:0]    out_col,
  output logic             out_sol,
  output logic             out_eof,
  output logic             win_valid,
  output logic             done
);

  localparam int NPIX = length * length;

  logic [WIDTH-1:0] r_mem [NPIX];
  logic [1:0]       r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic             r_sol;
  logic             r_eof;
  logic             r_win;
  logic             r_done;

  logic             w_idle;
  logic             w_stream;
  logic             w_wr_ok;
  logic             w_clr;
  logic             w_load;
  logic             w_fin;
  logic [CW-1:0]    w_row;
  logic [CW-1:0]    w_col;
  logic             w_sol;
  logic             w_eof;
  logic             w_win;
  logic [AW-1:0]    w_rd_addr;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_stream = (r_state == ST_STREAM);
  assign w_wr_ok  = wr_en && w_idle && (32'(wr_addr) < NPIX);
  assign w_clr    = w_idle && start;
  // Once the last pixel sits in the output register nothing more loads.
  assign w_load   = w_stream && (!r_valid || (out_ready && !r_eof));
  assign w_fin    = w_stream && r_valid && out_ready && r_eof;
  assign w_rd_addr = AW'(int'(w_row) * length + int'(w_col));

  pixel_pos_counter #(
    .length (length),
    .column (column),
    .CW     (CW)
  ) u_pos (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_adv (w_load),
    .o_row (w_row),
    .o_col (w_col),
    .o_sol (w_sol),
    .o_eof (w_eof),
    .o_win (w_win)
  );

  // Map buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[wr_addr] <= wr_data;
  end

  // Control FSM: idle, streaming, one-cycle done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) r_state <= ST_STREAM;
        ST_STREAM: if (w_fin) r_state <= ST_DONE;
        ST_DONE:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: advances only on a free slot or a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_sol   <= 1'b0;
      r_eof   <= 1'b0;
      r_win   <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= r_mem[w_rd_addr];
      r_row   <= w_row;
      r_col   <= w_col;
      r_sol   <= w_sol;
      r_eof   <= w_eof;
      r_win   <= w_win;
    end else if (w_fin) begin
      r_valid <= 1'b0;
    end
  end

  // Done pulses the cycle after the last pixel handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= w_fin;
  end

  assign busy      = !w_idle;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_row   = r_row;
  assign out_col   = r_col;
  assign out_sol   = r_sol;
  assign out_eof   = r_eof;
  assign win_valid = r_win;
  assign done      = r_done;

endmodule

// File: tb/tb_module_pixel_stream_feed.sv
// Directed bench for the pixel stream feeder.
// Covers 8x8/3x3 and 3x3/3x3 maps.
module tb_module_pixel_stream_feed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [17:0] wr_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [17:0] out_data;
  logic [2:0]  out_row;
  logic [2:0]  out_col;
  logic        out_sol;
  logic        out_eof;
  logic        win_valid;
  logic        done;

  logic        s_wr_en = 1'b0;
  logic [3:0]  s_wr_addr = '0;
  logic [17:0] s_wr_data = '0;
  logic        s_start = 1'b0;
  logic        s_busy;
  logic        s_valid;
  logic [17:0] s_data;
  logic [1:0]  s_row;
  logic [1:0]  s_col;
  logic        s_sol;
  logic        s_eof;
  logic        s_win;
  logic        s_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_mem [64];
  logic [3:0]  pat = 4'b1001;

  always #5 clk = ~clk;

  module_pixel_stream_feed #(.WIDTH(18), .length(8), .column(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_sol(out_sol),
    .out_eof(out_eof), .win_valid(win_valid), .done(done)
  );

  module_pixel_stream_feed #(.WIDTH(18), .length(3), .column(3)) dut_s (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .start(s_start), .busy(s_busy),
    .out_valid(s_valid), .out_ready(1'b1), .out_data(s_data),
    .out_row(s_row), .out_col(s_col), .out_sol(s_sol),
    .out_eof(s_eof), .win_valid(s_win), .done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_row"}, out_row, 0);
    chk({tag, "_col"}, out_col, 0);
    chk({tag, "_sol"}, out_sol, 0);
    chk({tag, "_eof"}, out_eof, 0);
    chk({tag, "_win"}, win_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run(input int mode, input bit disturb,
                     input int abort_at, input bit wr0);
    int  beat;
    int  wins;
    bit  held;
    bit  fin;
    bit  rdy;
    beat = 0;
    wins = 0;
    held = 0;
    fin  = 0;
    @(negedge clk);
    start = 1'b1;
    if (wr0) begin
      wr_en   = 1'b1;
      wr_addr = 6'd0;
      wr_data = 18'h3FFFF;
    end
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (out_valid) begin
        chk("data", out_data, exp_mem[beat]);
        chk("row", out_row, beat / 8);
        chk("col", out_col, beat % 8);
        chk("busy", busy, 1);
        if (!held) begin
          chk("sol", out_sol, (beat % 8) == 0);
          chk("eof", out_eof, beat == 63);
          chk("win", win_valid, (beat / 8 >= 2) && (beat % 8 >= 2));
          if (win_valid) wins++;
          if (beat == abort_at) begin
            rst = 1'b1;
            #1;
            chk_zero("abort");
            @(negedge clk);
            chk("abort_done", done, 0);
            rst = 1'b0;
            fin = 1;
          end else if (disturb && beat == 10) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 6'd5;
            wr_data = 18'h12345;
          end
        end
        if (!fin) begin
          rdy = (mode == 0) ? 1'b1 : pat[cyc % 4];
          out_ready = rdy;
          held = !rdy;
          if (rdy) beat++;
        end
      end else if (beat == 64) begin
        chk("done_pulse", done, 1);
        @(negedge clk);
        chk("done_low", done, 0);
        chk("busy_low", busy, 0);
        fin = 1;
      end
    end
    if (abort_at < 0) begin
      chk("beats", beat, 64);
      chk("wins", wins, 36);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int beat;
    int wins;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 6'(i);
      wr_data = 18'(i);
      exp_mem[i] = 18'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("idle_busy", busy, 0);

    run(0, 0, -1, 0);
    run(1, 0, -1, 0);
    run(0, 1, -1, 0);
    run(0, 0, -1, 0);
    exp_mem[0] = 18'h3FFFF;
    run(0, 0, -1, 1);
    run(0, 0, 20, 0);
    run(1, 0, -1, 0);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      s_wr_en   = 1'b1;
      s_wr_addr = 4'(i);
      s_wr_data = 18'(100 + i);
    end
    @(negedge clk);
    s_wr_en = 1'b0;
    s_start = 1'b1;
    beat = 0;
    wins = 0;
    for (int cyc = 0; cyc < 50 && beat < 9; cyc++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (s_valid) begin
        chk("s_data", s_data, 100 + beat);
        chk("s_row", s_row, beat / 3);
        chk("s_col", s_col, beat % 3);
        chk("s_win", s_win, beat == 8);
        chk("s_eof", s_eof, beat == 8);
        if (s_win) wins++;
        beat++;
      end
    end
    chk("s_beats", beat, 9);
    chk("s_wins", wins, 1);
    @(negedge clk);
    chk("s_done", s_done, 1);
    chk("s_valid_end", s_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
